// File: rtl/th_refill.sv
// Lookup/update responder: acks fetch-unit lookups, refills missed lines from memory as a counted burst.
// Optional TH_REFILL_CRIT_FIRST_EN: burst starts at the requested word and wraps within the line.
module th_refill #(
  parameter int ADDRESS = 10,
  parameter int LINE    = 4,
  parameter int WORDS   = 8
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  input  logic                          lk_lookup_i,
  output logic                          lk_ack_o,
  input  logic [LINE-1:0]               lk_l_addr_i,
  input  logic                          lk_packed_i,
  input  logic [ADDRESS-1:0]            lk_pc_i,
  output logic                          lk_busy_o,
  input  logic                          lk_hit_i,
  input  logic                          lk_miss_i,
  output logic                          lk_update_o,
  output logic [LINE-1:0]               lk_u_addr_o,
  output logic                          lk_packed_o,
  output logic                          mem_req_o,
  output logic [ADDRESS-1:0]            mem_addr_o,
  input  logic                          mem_rdy_i,
  output logic                          lb_we_o,
  output logic [LINE+$clog2(WORDS)-1:0] lb_addr_o
);

  localparam int BW = $clog2(WORDS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACK    = 3'd1,
    S_WAIT   = 3'd2,
    S_FILL   = 3'd3,
    S_UPDATE = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [LINE-1:0]    line_q, line_d;
  logic [ADDRESS-1:0] pc_q, pc_d;
  logic               packed_q, packed_d;
  logic [BW-1:0]      beat_q, beat_d;
  logic [BW-1:0]      cnt_q, cnt_d;
  logic               ack_q, ack_d;
  logic               busy_q, busy_d;
  logic [BW-1:0]      last_cnt;
  logic [BW-1:0]      start_beat;
  logic [BW-1:0]      next_beat;

  assign last_cnt = packed_q ? BW'(WORDS / 2 - 1) : BW'(WORDS - 1);

`ifdef TH_REFILL_CRIT_FIRST_EN
  // Packed lines only span half the beats, so both the start and the wrap use the half-line mask.
  assign start_beat = packed_q ? (pc_q[BW-1:0] & BW'(WORDS / 2 - 1)) : pc_q[BW-1:0];
  assign next_beat  = packed_q ? ((beat_q + BW'(1)) & BW'(WORDS / 2 - 1)) : (beat_q + BW'(1));
`else
  logic unused_pc_lo;
  assign unused_pc_lo = ^pc_q[BW-1:0];
  assign start_beat   = '0;
  assign next_beat    = beat_q + BW'(1);
`endif

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      line_q   <= '0;
      pc_q     <= '0;
      packed_q <= 1'b0;
      beat_q   <= '0;
      cnt_q    <= '0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      line_q   <= line_d;
      pc_q     <= pc_d;
      packed_q <= packed_d;
      beat_q   <= beat_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    line_d   = line_q;
    pc_d     = pc_q;
    packed_d = packed_q;
    beat_d   = beat_q;
    cnt_d    = cnt_q;
    ack_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (lk_lookup_i) begin
          line_d   = lk_l_addr_i;
          pc_d     = lk_pc_i;
          packed_d = lk_packed_i;
          ack_d    = 1'b1;
          state_d  = S_ACK;
        end
      end
      S_ACK:  state_d = S_WAIT;
      S_WAIT: begin
        if (lk_miss_i) begin
          cnt_d   = '0;
          beat_d  = start_beat;
          state_d = S_FILL;
        end else if (lk_hit_i) begin
          state_d = S_IDLE;
        end
      end
      S_FILL: begin
        // The beat counter only addresses; the separate count decides when the burst is done.
        if (mem_rdy_i) begin
          cnt_d  = cnt_q + BW'(1);
          beat_d = next_beat;
          if (cnt_q == last_cnt) state_d = S_UPDATE;
        end
      end
      S_UPDATE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_FILL) || (state_d == S_UPDATE);
  end

  assign lk_ack_o    = ack_q;
  assign lk_busy_o   = busy_q;
  assign mem_req_o   = (state_q == S_FILL);
  assign lb_we_o     = mem_req_o & mem_rdy_i;
  assign mem_addr_o  = {pc_q[ADDRESS-1:BW], beat_q};
  assign lb_addr_o   = {line_q, beat_q};
  assign lk_update_o = (state_q == S_UPDATE);
  assign lk_u_addr_o = lk_update_o ? line_q : '0;
  assign lk_packed_o = lk_update_o & packed_q;

endmodule
